mux_select_arbiter: RTL and testbench



---
 rtl/mux_select_arbiter_if.sv | 13 +
 rtl/mux_select_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_select_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mux_select_arbiter_if.sv
// Request/select bundle between the two requesters and the select generator
// feeding the shared AND-OR data mux.
interface mux_select_arbiter_if;
  logic REQ1;
  logic REQ2;
  logic SEL1;
  logic SEL2;
  logic BUSY;
  logic TIMEOUT;

  modport master (output REQ1, REQ2, input SEL1, SEL2, BUSY, TIMEOUT);
  modport slave  (input REQ1, REQ2, output SEL1, SEL2, BUSY, TIMEOUT);
endinterface

// File: rtl/mux_select_arbiter.sv
// Registered, mutually exclusive SEL1/SEL2 generator with break-before-make gap and hold limit.
// Define MUXSEL_ROUNDROBIN_EN to alternate simultaneous requests; default is fixed REQ1 priority.
module mux_select_arbiter #(
  parameter int MAX_HOLD   = 15,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mux_select_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       gap_cnt;
  logic             lock1;
  logic             lock2;
  logic             elig1;
  logic             elig2;
  logic             pick1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic at_limit(input logic [CNT_W-1:0] v);
    return (MAX_HOLD != 0) && (v == CNT_W'(MAX_HOLD));
  endfunction

  // A requester that timed out stays ineligible until its REQ is seen low.
  assign elig1 = bus.REQ1 & ~lock1;
  assign elig2 = bus.REQ2 & ~lock2;

`ifdef MUXSEL_ROUNDROBIN_EN
  logic last_gnt;  // 1: requester 2 was granted last, so requester 1 wins the next tie

  assign pick1 = elig1 & (~elig2 | last_gnt);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_gnt <= 1'b1;
    end else if (state == IDLE) begin
      if (pick1)      last_gnt <= 1'b0;
      else if (elig2) last_gnt <= 1'b1;
    end
  end
`else
  assign pick1 = elig1;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      bus.SEL1    <= 1'b0;
      bus.SEL2    <= 1'b0;
      bus.BUSY    <= 1'b0;
      bus.TIMEOUT <= 1'b0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      lock1       <= 1'b0;
      lock2       <= 1'b0;
    end else begin
      bus.TIMEOUT <= 1'b0;
      lock1       <= lock1 & bus.REQ1;
      lock2       <= lock2 & bus.REQ2;
      case (state)
        IDLE: begin
          if (pick1) begin
            state    <= GNT1;
            bus.SEL1 <= 1'b1;
            bus.BUSY <= 1'b1;
            hold_cnt <= CNT_W'(1);
          end else if (elig2) begin
            state    <= GNT2;
            bus.SEL2 <= 1'b1;
            bus.BUSY <= 1'b1;
            hold_cnt <= CNT_W'(1);
          end
        end
        GNT1: begin
          // A release on the limit cycle is normal; only a still-held REQ times out.
          if (!bus.REQ1) begin
            state    <= GAP;
            bus.SEL1 <= 1'b0;
            gap_cnt  <= 3'd1;
          end else if (at_limit(hold_cnt)) begin
            state       <= GAP;
            bus.SEL1    <= 1'b0;
            gap_cnt     <= 3'd1;
            bus.TIMEOUT <= 1'b1;
            lock1       <= 1'b1;
          end else begin
            hold_cnt <= sat_inc(hold_cnt);
          end
        end
        GNT2: begin
          if (!bus.REQ2) begin
            state    <= GAP;
            bus.SEL2 <= 1'b0;
            gap_cnt  <= 3'd1;
          end else if (at_limit(hold_cnt)) begin
            state       <= GAP;
            bus.SEL2    <= 1'b0;
            gap_cnt     <= 3'd1;
            bus.TIMEOUT <= 1'b1;
            lock2       <= 1'b1;
          end else begin
            hold_cnt <= sat_inc(hold_cnt);
          end
        end
        default: begin
          hold_cnt <= '0;
          if (gap_cnt >= 3'(GAP_CYCLES)) begin
            state    <= IDLE;
            bus.BUSY <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed scoreboard bench for mux_select_arbiter plus a free-running select-invariant monitor.
module tb_mux_select_arbiter;

  localparam int GAP = 1;

`ifdef MUXSEL_ROUNDROBIN_EN
  localparam logic [3:0] TIE_EXP = 4'b0110;
`else
  localparam logic [3:0] TIE_EXP = 4'b1010;
`endif

  typedef struct {
    logic [3:0] exp;
    int         tag;
  } item_t;

  logic  CLK = 1'b0;
  logic  RESET;
  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  always #5 CLK = ~CLK;

  mux_select_arbiter_if bus ();

  mux_select_arbiter #(.MAX_HOLD(15), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  // Expected {SEL1,SEL2,BUSY,TIMEOUT} after the edge that captures each vector.
  task automatic seg(input int n, input logic r1, input logic r2, input logic [3:0] exp, input int tag);
    item_t it;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bus.REQ1 = r1;
      bus.REQ2 = r2;
      it.exp = exp;
      it.tag = tag;
      sbq.push_back(it);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() > 0 && k < 200) begin
      @(posedge CLK);
      #3;
      k++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin : monitor
    item_t      it;
    logic [3:0] act;
    forever begin
      @(posedge CLK);
      #2;
      if (sbq.size() > 0) begin
        it  = sbq.pop_front();
        act = {bus.SEL1, bus.SEL2, bus.BUSY, bus.TIMEOUT};
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL seg%0d sel1_sel2_busy_timeout got %b want %b at %0t", it.tag, act, it.exp, $time);
        end
      end
    end
  end

  initial begin : invariants
    int   zero_run;
    logic prev_any;
    logic any;
    zero_run = 100;
    prev_any = 1'b0;
    forever begin
      @(posedge CLK);
      #3;
      if (RESET) begin
        zero_run = 100;
        prev_any = 1'b0;
      end else begin
        checks++;
        any = bus.SEL1 | bus.SEL2;
        if (bus.SEL1 && bus.SEL2) begin
          errors++;
          $display("FAIL sel_exclusive got SEL1=%b SEL2=%b want not both 1", bus.SEL1, bus.SEL2);
        end else if (any && !prev_any && zero_run < GAP) begin
          errors++;
          $display("FAIL grant_gap got %0d zero cycles want >= %0d", zero_run, GAP);
        end
        zero_run = any ? 0 : zero_run + 1;
        prev_any = any;
      end
    end
  end

  initial begin : stim
    RESET    = 1'b1;
    bus.REQ1 = 1'b0;
    bus.REQ2 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({bus.SEL1, bus.SEL2, bus.BUSY, bus.TIMEOUT} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got %b want 0000", {bus.SEL1, bus.SEL2, bus.BUSY, bus.TIMEOUT});
    end
    @(negedge CLK);
    RESET = 1'b0;

    // Simultaneous requests straight after reset: REQ1 preferred first.
    seg(3, 1'b1, 1'b1, 4'b1010, 40);
    seg(1, 1'b0, 1'b1, 4'b0010, 41);
    seg(1, 1'b1, 1'b1, 4'b0000, 42);
    seg(2, 1'b1, 1'b1, TIE_EXP, 43);
    seg(1, 1'b0, 1'b0, 4'b0010, 44);
    seg(1, 1'b0, 1'b0, 4'b0000, 45);
    drain();

    // REQ1 for five cycles, then one gap cycle.
    seg(2, 1'b0, 1'b0, 4'b0000, 10);
    seg(5, 1'b1, 1'b0, 4'b1010, 11);
    seg(1, 1'b0, 1'b0, 4'b0010, 12);
    seg(2, 1'b0, 1'b0, 4'b0000, 13);
    drain();

    // REQ2 held 40 cycles: 15-cycle grant, timeout, lockout until REQ2 drops.
    seg(15, 1'b0, 1'b1, 4'b0110, 20);
    seg(1,  1'b0, 1'b1, 4'b0011, 21);
    seg(24, 1'b0, 1'b1, 4'b0000, 22);
    seg(1,  1'b0, 1'b0, 4'b0000, 23);
    seg(3,  1'b0, 1'b1, 4'b0110, 24);
    seg(1,  1'b0, 1'b0, 4'b0010, 25);
    seg(1,  1'b0, 1'b0, 4'b0000, 26);
    drain();

    // REQ1 drops exactly when the counter reaches the limit: no timeout.
    seg(15, 1'b1, 1'b0, 4'b1010, 30);
    seg(1,  1'b0, 1'b0, 4'b0010, 31);
    seg(1,  1'b0, 1'b0, 4'b0000, 32);
    drain();

    // Asynchronous reset in the middle of a GNT2 grant.
    seg(3, 1'b0, 1'b1, 4'b0110, 50);
    drain();
    RESET = 1'b1;
    #1;
    checks++;
    if ({bus.SEL1, bus.SEL2, bus.BUSY, bus.TIMEOUT} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got %b want 0000", {bus.SEL1, bus.SEL2, bus.BUSY, bus.TIMEOUT});
    end
    @(negedge CLK);
    bus.REQ2 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    seg(2, 1'b0, 1'b0, 4'b0000, 51);
    seg(1, 1'b0, 1'b1, 4'b0110, 52);
    seg(1, 1'b0, 1'b0, 4'b0010, 53);
    seg(1, 1'b0, 1'b0, 4'b0000, 54);
    drain();

    // Random requests; only the invariant monitor judges this phase.
    for (int i = 0; i < 10000; i++) begin
      @(negedge CLK);
      bus.REQ1 = 1'($urandom_range(0, 1));
      bus.REQ2 = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    bus.REQ1 = 1'b0;
    bus.REQ2 = 1'b0;
    repeat (4) @(posedge CLK);
    #4;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
